// File: rtl/cpu_types_pkg.sv
// Shared CPU types: register index, data word, hazard controller state.
package cpu_types_pkg;

    typedef logic [4:0]  regbits_t;
    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DWAIT  = 2'd1,
        HALTED = 2'd2
    } hazard_state_t;

    localparam word_t WORD_MAX = 32'hFFFF_FFFF;

    // Increment that sticks at the all-ones value instead of wrapping.
    function automatic word_t sat_inc(input word_t v);
        return (v == WORD_MAX) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detect: the load in ID/EX writes a register the
// instruction in IF/ID reads. Register 0 is never a real dependency.
module load_use_detect
    import cpu_types_pkg::*;
(
    input  logic     idex_dmemREN,
    input  regbits_t idex_rt,
    input  regbits_t ifid_rs,
    input  regbits_t ifid_rt,
    output logic     lu
);

    logic w_nonzero;
    logic w_match;

    assign w_nonzero = (idex_rt != 5'd0);
    assign w_match   = (idex_rt == ifid_rs) || (idex_rt == ifid_rt);
    assign lu        = idex_dmemREN && w_nonzero && w_match;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline. Latch and PC
// controls are combinational from the inputs and the HALTED state; the
// state machine and performance counters are clocked.
module pipeline_hazard_ctrl
    import cpu_types_pkg::*;
(
    input  logic     CLK,
    input  logic     nRST,
    input  logic     ihit,
    input  logic     dhit,
    input  logic     exmem_dmemREN,
    input  logic     exmem_dmemWEN,
    input  logic     idex_dmemREN,
    input  regbits_t idex_rt,
    input  regbits_t ifid_rs,
    input  regbits_t ifid_rt,
    input  logic     ex_redirect,
    input  logic     memwb_halt,
    output logic     pc_wen,
    output logic     ifid_wen,
    output logic     ifid_flush,
    output logic     idex_wen,
    output logic     idex_flush,
    output logic     exmem_wen,
    output logic     exmem_flush,
    output logic     memwb_wen,
    output logic     memwb_flush,
    output logic     halted,
    output word_t    stall_count,
    output word_t    flush_count
);

    hazard_state_t r_state;
    hazard_state_t w_next;
    word_t         r_stall_count;
    word_t         r_flush_count;

    logic w_lu;
    logic w_mem_wait;
    logic w_redirect_fire;
    logic w_pc_wen, w_ifid_wen, w_ifid_flush, w_idex_wen, w_idex_flush;
    logic w_exmem_wen, w_exmem_flush, w_memwb_wen, w_memwb_flush;

    load_use_detect u_lu (
        .idex_dmemREN (idex_dmemREN),
        .idex_rt      (idex_rt),
        .ifid_rs      (ifid_rs),
        .ifid_rt      (ifid_rt),
        .lu           (w_lu)
    );

    assign w_mem_wait = (exmem_dmemREN || exmem_dmemWEN) && !dhit;

    // State register; reset mid-wait drops straight back to RUN.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) r_state <= RUN;
        else       r_state <= w_next;
    end

    // Priority mux for latch controls plus next-state; DWAIT and RUN share outputs.
    always_comb begin
        w_next          = r_state;
        w_redirect_fire = 1'b0;
        w_pc_wen        = 1'b1;
        w_ifid_wen      = 1'b1;
        w_idex_wen      = 1'b1;
        w_exmem_wen     = 1'b1;
        w_memwb_wen     = 1'b1;
        w_ifid_flush    = 1'b0;
        w_idex_flush    = 1'b0;
        w_exmem_flush   = 1'b0;
        w_memwb_flush   = 1'b0;
        if (r_state == HALTED) begin
            w_pc_wen    = 1'b0;
            w_ifid_wen  = 1'b0;
            w_idex_wen  = 1'b0;
            w_exmem_wen = 1'b0;
            w_memwb_wen = 1'b0;
        end else if (w_mem_wait) begin
            // Freeze everything up to EX/MEM; push a bubble into WB.
            w_pc_wen      = 1'b0;
            w_ifid_wen    = 1'b0;
            w_idex_wen    = 1'b0;
            w_exmem_wen   = 1'b0;
            w_memwb_flush = 1'b1;
            w_next        = DWAIT;
        end else begin
            if (ex_redirect) begin
                w_redirect_fire = 1'b1;
                w_ifid_flush    = 1'b1;
                w_idex_flush    = 1'b1;
            end else if (w_lu) begin
                w_pc_wen     = 1'b0;
                w_ifid_wen   = 1'b0;
                w_idex_flush = 1'b1;
            end else if (!ihit) begin
                w_pc_wen     = 1'b0;
                w_ifid_flush = 1'b1;
            end
            // Halt only takes effect once no memory access is outstanding.
            w_next = memwb_halt ? HALTED : RUN;
        end
    end

    // Performance counters; saturate rather than wrap.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_stall_count <= '0;
            r_flush_count <= '0;
        end else begin
            if ((r_state != HALTED) && !w_pc_wen)
                r_stall_count <= sat_inc(r_stall_count);
            if (w_redirect_fire)
                r_flush_count <= sat_inc(r_flush_count);
        end
    end

    // Controls are forced quiet while reset is held.
    assign pc_wen      = nRST && w_pc_wen;
    assign ifid_wen    = nRST && w_ifid_wen;
    assign ifid_flush  = nRST && w_ifid_flush;
    assign idex_wen    = nRST && w_idex_wen;
    assign idex_flush  = nRST && w_idex_flush;
    assign exmem_wen   = nRST && w_exmem_wen;
    assign exmem_flush = nRST && w_exmem_flush;
    assign memwb_wen   = nRST && w_memwb_wen;
    assign memwb_flush = nRST && w_memwb_flush;

    assign halted      = (r_state == HALTED);
    assign stall_count = r_stall_count;
    assign flush_count = r_flush_count;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomized + directed bench for pipeline_hazard_ctrl with a rule-level
// reference model of the controls, halt flag, wait tracking and counters.
module tb_pipeline_hazard_ctrl;
    import cpu_types_pkg::*;

    logic     CLK = 1'b0;
    logic     nRST = 1'b0;
    logic     ihit, dhit, exmem_dmemREN, exmem_dmemWEN, idex_dmemREN;
    regbits_t idex_rt, ifid_rs, ifid_rt;
    logic     ex_redirect, memwb_halt;
    logic     pc_wen, ifid_wen, ifid_flush, idex_wen, idex_flush;
    logic     exmem_wen, exmem_flush, memwb_wen, memwb_flush, halted;
    word_t    stall_count, flush_count;

    int n_tests = 0;
    int n_fail  = 0;

    // model state
    logic     m_halted;
    logic     m_wait;
    logic [31:0] m_stall;
    logic [31:0] m_flush;

    pipeline_hazard_ctrl dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
        .exmem_dmemREN(exmem_dmemREN), .exmem_dmemWEN(exmem_dmemWEN),
        .idex_dmemREN(idex_dmemREN), .idex_rt(idex_rt),
        .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
        .ex_redirect(ex_redirect), .memwb_halt(memwb_halt),
        .pc_wen(pc_wen), .ifid_wen(ifid_wen), .ifid_flush(ifid_flush),
        .idex_wen(idex_wen), .idex_flush(idex_flush),
        .exmem_wen(exmem_wen), .exmem_flush(exmem_flush),
        .memwb_wen(memwb_wen), .memwb_flush(memwb_flush),
        .halted(halted), .stall_count(stall_count), .flush_count(flush_count)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Order: pc_wen, ifid_wen, ifid_flush, idex_wen, idex_flush,
    //        exmem_wen, exmem_flush, memwb_wen, memwb_flush
    function automatic logic [8:0] ctrl_vec();
        return {pc_wen, ifid_wen, ifid_flush, idex_wen, idex_flush,
                exmem_wen, exmem_flush, memwb_wen, memwb_flush};
    endfunction

    function automatic logic model_lu();
        return idex_dmemREN && (idex_rt != 0) &&
               ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));
    endfunction

    function automatic logic model_memwait();
        return (exmem_dmemREN || exmem_dmemWEN) && !dhit;
    endfunction

    // Which rule applies this cycle: 0 reset/halt, 2 mem wait, 3 redirect,
    // 4 load-use, 5 fetch miss, 6 free-running.
    function automatic int model_rule();
        if (!nRST || m_halted)  return 0;
        if (model_memwait())    return 2;
        if (ex_redirect)        return 3;
        if (model_lu())         return 4;
        if (!ihit)              return 5;
        return 6;
    endfunction

    function automatic logic [8:0] model_ctrl(input int rule);
        case (rule)
            0: return 9'b0_0_0_0_0_0_0_0_0;
            2: return 9'b0_0_0_0_0_0_0_1_1;
            3: return 9'b1_1_1_1_1_1_0_1_0;
            4: return 9'b0_0_0_1_1_1_0_1_0;
            5: return 9'b0_1_1_1_0_1_0_1_0;
            default: return 9'b1_1_0_1_0_1_0_1_0;
        endcase
    endfunction

    function automatic logic [63:0] model_state();
        if (m_halted) return 64'(HALTED);
        if (m_wait)   return 64'(DWAIT);
        return 64'(RUN);
    endfunction

    function automatic logic [31:0] sat(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 1;
    endfunction

    task automatic check_now();
        int r;
        r = model_rule();
        chk("ctrl",      64'(ctrl_vec()),   64'(model_ctrl(r)));
        chk("halted",    64'(halted),       64'(m_halted));
        chk("stall_cnt", 64'(stall_count),  64'(m_stall));
        chk("flush_cnt", 64'(flush_count),  64'(m_flush));
        chk("state",     64'(dut.r_state),  model_state());
    endtask

    // Inputs are already driven (just after a negedge). Check, then clock.
    task automatic cycle();
        int  r;
        logic n_halted, n_wait;
        logic [31:0] n_stall, n_flush;
        #1;
        check_now();
        r = model_rule();
        n_halted = m_halted; n_wait = m_wait; n_stall = m_stall; n_flush = m_flush;
        if (!m_halted) begin
            if (r == 2 || r == 4 || r == 5) n_stall = sat(m_stall);
            if (r == 3) n_flush = sat(m_flush);
            if (r == 2) n_wait = 1'b1;
            else begin
                n_wait = 1'b0;
                if (memwb_halt) n_halted = 1'b1;
            end
        end
        @(posedge CLK);
        m_halted = n_halted; m_wait = n_wait; m_stall = n_stall; m_flush = n_flush;
        @(negedge CLK);
    endtask

    task automatic quiet();
        ihit = 1; dhit = 0; exmem_dmemREN = 0; exmem_dmemWEN = 0;
        idex_dmemREN = 0; idex_rt = 0; ifid_rs = 0; ifid_rt = 0;
        ex_redirect = 0; memwb_halt = 0;
    endtask

    // Assert reset at a negedge, check the async effect, release.
    task automatic do_reset();
        nRST = 0;
        #1;
        m_halted = 0; m_wait = 0; m_stall = 0; m_flush = 0;
        chk("rst_ctrl",  64'(ctrl_vec()), 64'd0);
        chk("rst_state", 64'(dut.r_state), 64'(RUN));
        chk("rst_stall", 64'(stall_count), 64'd0);
        chk("rst_flush", 64'(flush_count), 64'd0);
        chk("rst_halt",  64'(halted), 64'd0);
        @(negedge CLK);
        nRST = 1;
    endtask

    task automatic rand_inputs(input bit allow_halt);
        ihit          = ($urandom % 4) != 0;
        dhit          = ($urandom % 3) == 0;
        exmem_dmemREN = ($urandom % 5) == 0;
        exmem_dmemWEN = ($urandom % 6) == 0;
        idex_dmemREN  = $urandom % 2;
        idex_rt       = regbits_t'($urandom % 4);
        ifid_rs       = regbits_t'($urandom % 4);
        ifid_rt       = regbits_t'($urandom % 4);
        ex_redirect   = ($urandom % 6) == 0;
        memwb_halt    = allow_halt && (($urandom % 48) == 0);
    endtask

    initial begin
        int halted_cycles;
        quiet();
        m_halted = 0; m_wait = 0; m_stall = 0; m_flush = 0;
        @(negedge CLK);
        do_reset();

        // Reset in the middle of a data wait.
        exmem_dmemREN = 1; dhit = 0;
        repeat (3) cycle();
        chk("dwait_state", 64'(dut.r_state), 64'(DWAIT));
        do_reset();
        quiet();

        // Load-use stall, then the same pattern against r0.
        idex_dmemREN = 1; idex_rt = 8; ifid_rs = 8; ifid_rt = 3; ihit = 1;
        #1;
        chk("lu_pc",   64'(pc_wen), 64'd0);
        chk("lu_ifid", 64'(ifid_wen), 64'd0);
        chk("lu_idfl", 64'(idex_flush), 64'd1);
        cycle();
        chk("lu_stall", 64'(stall_count), 64'd1);
        idex_rt = 0; ifid_rs = 0;
        cycle();
        chk("lu_r0_stall", 64'(stall_count), 64'd1);

        // Four-cycle store wait then completion.
        do_reset(); quiet();
        exmem_dmemWEN = 1; dhit = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("mw_memwb_flush", 64'(memwb_flush), 64'd1);
            chk("mw_pc",          64'(pc_wen), 64'd0);
            cycle();
        end
        dhit = 1;
        #1;
        chk("mw_dhit_wen", 64'({pc_wen, ifid_wen, idex_wen, exmem_wen, memwb_wen}), 64'h1F);
        cycle();
        chk("mw_state_run", 64'(dut.r_state), 64'(RUN));
        chk("mw_stall4",    64'(stall_count), 64'd4);

        // Redirect together with a load-use match.
        do_reset(); quiet();
        ex_redirect = 1; idex_dmemREN = 1; idex_rt = 5; ifid_rt = 5;
        cycle();
        chk("rd_flush1", 64'(flush_count), 64'd1);
        chk("rd_stall0", 64'(stall_count), 64'd0);

        // Saturation: pin the flush counter at max across a redirect edge.
        quiet(); ex_redirect = 1;
        force dut.r_flush_count = 32'hFFFF_FFFF;
        m_flush = 32'hFFFF_FFFF;
        cycle();
        release dut.r_flush_count;
        #1;
        chk("sat_hold", 64'(flush_count), 64'hFFFF_FFFF);
        cycle();
        cycle();
        chk("sat_after", 64'(flush_count), 64'hFFFF_FFFF);

        // Randomized run against the model, with periodic resets.
        do_reset(); quiet();
        halted_cycles = 0;
        for (int i = 0; i < 1500; i++) begin
            if (($urandom % 90) == 0 || halted_cycles > 6) begin
                do_reset();
                halted_cycles = 0;
            end
            rand_inputs(1'b1);
            cycle();
            if (m_halted) halted_cycles++;
        end

        // Halt requested during a pending store waits for dhit.
        do_reset(); quiet();
        memwb_halt = 1; exmem_dmemWEN = 1; dhit = 0;
        cycle();
        chk("halt_wait", 64'(halted), 64'd0);
        dhit = 1;
        cycle();
        chk("halt_set", 64'(halted), 64'd1);
        quiet(); ex_redirect = 1;
        #1;
        chk("halt_ctrl0", 64'(ctrl_vec()), 64'd0);
        cycle();
        chk("halt_sticky", 64'(halted), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Watchdog against a stuck run.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush controller for the 5-stage pipelined CPU. It drives the `wen` and `flush` inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB latches, plus the PC write enable. It resolves memory waits, taken branches/jumps, load-use hazards, fetch misses and halt. It holds a small state machine for data-memory wait and halt, and 32-bit saturating stall and flush performance counters.

## Interface
- Parameters: none; widths come from `cpu_types_pkg`.
- `CLK` in 1: system clock, rising edge.
- `nRST` in 1: reset, asynchronous, active-low.
- `ihit` in 1: instruction fetch complete this cycle.
- `dhit` in 1: data access complete this cycle.
- `exmem_dmemREN` in 1: EX/MEM stage holds a load.
- `exmem_dmemWEN` in 1: EX/MEM stage holds a store.
- `idex_dmemREN` in 1: ID/EX stage holds a load.
- `idex_rt` in 5: destination register of the ID/EX load.
- `ifid_rs` in 5: source register of the instruction in IF/ID.
- `ifid_rt` in 5: source register of the instruction in IF/ID.
- `ex_redirect` in 1: taken branch or jump resolved in EX.
- `memwb_halt` in 1: halt instruction present in MEM/WB.
- `pc_wen` out 1: PC write enable.
- `ifid_wen`, `ifid_flush` out 1 each: IF/ID latch controls.
- `idex_wen`, `idex_flush` out 1 each: ID/EX latch controls.
- `exmem_wen`, `exmem_flush` out 1 each: EX/MEM latch controls.
- `memwb_wen`, `memwb_flush` out 1 each: MEM/WB latch controls.
- `halted` out 1: sticky halt indication, registered.
- `stall_count` out 32: cycles with `pc_wen`=0 in RUN or DWAIT, saturating.
- `flush_count` out 32: number of `ex_redirect` flushes, saturating.

## Operation
- States: RUN, DWAIT, HALTED. Reset state is RUN.
- `dmem_pend` = `exmem_dmemREN` | `exmem_dmemWEN`.
- Load-use hazard `lu` = `idex_dmemREN` & (`idex_rt`≠0) & (`idex_rt`==`ifid_rs` | `idex_rt`==`ifid_rt`).
- Default outputs: every `wen`=1, every `flush`=0.
- Priority, highest first, evaluated combinationally each cycle:
  1. HALTED: all `wen`=0, all `flush`=0.
  2. `dmem_pend` & !`dhit`:
     - `pc_wen`, `ifid_wen`, `idex_wen`, `exmem_wen` = 0.
     - `memwb_wen`=1 with `memwb_flush`=1, so a bubble enters WB.
  3. `ex_redirect`: `pc_wen`=1, `ifid_flush`=1, `idex_flush`=1; EX/MEM and MEM/WB advance.
  4. `lu`: `pc_wen`=0, `ifid_wen`=0, `idex_flush`=1; EX/MEM and MEM/WB advance.
  5. !`ihit`: `pc_wen`=0, `ifid_flush`=1; downstream latches advance.
- Transitions:
  - RUN→DWAIT when `dmem_pend` & !`dhit`.
  - DWAIT→RUN on `dhit`. The `dhit` cycle already uses the advance outputs for that cycle's inputs.
  - Any state→HALTED when `memwb_halt`=1 and rule 2 is not active. HALTED is left only by reset.
- DWAIT is bookkeeping for the counters and for bench visibility. Outputs depend on inputs and on HALTED only, so RUN and DWAIT produce identical outputs for identical inputs.
- Counters:
  - `stall_count` +1 on every cycle with `pc_wen`=0 while not HALTED.
  - `flush_count` +1 on every cycle where rule 3 fires.
  - Both hold at 32'hFFFF_FFFF.

## Timing
- All latch/PC controls are combinational: zero-cycle latency from inputs.
- `halted`, the state and the counters update on the rising `CLK` edge.
- Asynchronous reset (`nRST`=0):
  - `halted`=0, state=RUN, `stall_count`=0, `flush_count`=0.
  - While `nRST` is low, all `wen` and `flush` are forced to 0.
- Simultaneous events:
  - `ex_redirect` with `lu`: redirect wins, and no stall cycle is counted.
  - `ex_redirect` during a memory wait: the wait wins. The redirect is held by the frozen ID/EX→EX/MEM path and fires on the `dhit` cycle.
  - `memwb_halt` during a memory wait: HALTED is entered only after `dhit`.
- Reset during DWAIT returns to RUN immediately; no partial latch update occurs.

## Structure
- `cpu_types_pkg` gains `hazard_state_t` (enum RUN/DWAIT/HALTED). It reuses the existing `regbits_t` (5-bit) and `word_t` (32-bit) types.
- Sub-module `load_use_detect`: purely combinational, computing `lu` from `idex_dmemREN`, `idex_rt`, `ifid_rs`, `ifid_rt`.
- Top module holds the state register, halt flag, counters and the priority mux.

## Test plan
- Reset mid-DWAIT: drive `exmem_dmemREN`=1, `dhit`=0 for 3 cycles, then pulse `nRST` low. Expect state RUN, counters 0, all controls 0 while reset is low.
- Load-use: `idex_dmemREN`=1, `idex_rt`=8, `ifid_rs`=8, `ihit`=1. Expect `pc_wen`=0, `ifid_wen`=0, `idex_flush`=1, `stall_count` +1. Repeat with `idex_rt`=0: expect no stall.
- Memory wait: `exmem_dmemWEN`=1, `dhit`=0 for 4 cycles, then `dhit`=1.
  - Waiting cycles: PC/IF/ID/EX latch `wen`=0 and `memwb_flush`=1.
  - `dhit` cycle: all `wen`=1; state returns to RUN.
  - `stall_count`=4.
- Redirect beats load-use: `ex_redirect`=1 together with a load-use match. Expect `pc_wen`=1, `ifid_flush`=`idex_flush`=1, `flush_count`=1, `stall_count` unchanged.
- Halt ordering: `memwb_halt`=1 with a pending store and `dhit`=0. Expect not halted; after `dhit`=1, `halted`=1 next edge and all controls 0 thereafter.
- Saturation: preload `flush_count` near max via 2^32−1 forced redirect cycles (or a backdoor force). One more redirect leaves it at 32'hFFFF_FFFF.
